// File: rtl/seg_display_scan.sv
// Four-digit common-anode seven-segment scanner for the stopwatch.
// Snapshots the BCD digits once per frame and blinks the pair under adjustment.
module seg_display_scan #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned BLINK_DIV   = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] m10,
   input  logic [3:0] m1,
   input  logic [2:0] s10,
   input  logic [3:0] s1,
   input  logic       adj,
   input  logic       sel,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
   localparam int unsigned BLK_W = $clog2(BLINK_DIV);

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   logic [BLK_W-1:0] blk_cnt;
   logic             blink_off;

   logic [2:0] snap_m10;
   logic [3:0] snap_m1;
   logic [2:0] snap_s10;
   logic [3:0] snap_s1;

   logic       cnt_wrap_c;
   logic       blk_wrap_c;
   logic [3:0] digit_c;
   logic [3:0] digit_max_c;
   logic       blank_c;
   logic [6:0] seg_c;
   logic [3:0] an_c;
   logic       dp_c;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] code;
      case (v)
         4'd0:    code = 7'h40;
         4'd1:    code = 7'h79;
         4'd2:    code = 7'h24;
         4'd3:    code = 7'h30;
         4'd4:    code = 7'h19;
         4'd5:    code = 7'h12;
         4'd6:    code = 7'h02;
         4'd7:    code = 7'h78;
         4'd8:    code = 7'h00;
         4'd9:    code = 7'h10;
         default: code = SEG_DASH;
      endcase
      return code;
   endfunction

   assign cnt_wrap_c = (cnt == CNT_W'(REFRESH_DIV - 1));
   assign blk_wrap_c = (blk_cnt == BLK_W'(BLINK_DIV - 1));

   // Refresh slot counter and digit index; never stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt_wrap_c) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Capture at the frame boundary so one frame never mixes two counter values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snap_m10 <= '0;
         snap_m1  <= '0;
         snap_s10 <= '0;
         snap_s1  <= '0;
      end else if (cnt_wrap_c && (idx == 2'd3)) begin
         snap_m10 <= m10;
         snap_m1  <= m1;
         snap_s10 <= s10;
         snap_s1  <= s1;
      end
   end

   // Free-running blink phase.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blk_cnt   <= '0;
         blink_off <= 1'b0;
      end else if (blk_wrap_c) begin
         blk_cnt   <= '0;
         blink_off <= ~blink_off;
      end else begin
         blk_cnt <= blk_cnt + BLK_W'(1);
      end
   end

   // Select the digit for the current slot and build the next pin values.
   always_comb begin
      digit_c     = '0;
      digit_max_c = 4'd9;
      case (idx)
         2'd0: begin
            digit_c     = snap_s1;
            digit_max_c = 4'd9;
         end
         2'd1: begin
            digit_c     = {1'b0, snap_s10};
            digit_max_c = 4'd5;
         end
         2'd2: begin
            digit_c     = snap_m1;
            digit_max_c = 4'd9;
         end
         default: begin
            digit_c     = {1'b0, snap_m10};
            digit_max_c = 4'd5;
         end
      endcase

      blank_c = adj & blink_off & (sel ? ~idx[1] : idx[1]);

      if (blank_c) begin
         seg_c = SEG_BLANK;
      end else if (digit_c > digit_max_c) begin
         seg_c = SEG_DASH;
      end else begin
         seg_c = seg_decode(digit_c);
      end

      an_c = ~(4'b0001 << idx);
      dp_c = ~((idx == 2'd2) & ~blank_c);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an  <= 4'b1111;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end else begin
         an  <= an_c;
         seg <= seg_c;
         dp  <= dp_c;
      end
   end

endmodule

// File: tb/tb_seg_display_scan.sv
// Scoreboard bench for seg_display_scan with short refresh/blink periods.
module tb_seg_display_scan;

   localparam int unsigned REFRESH_DIV = 4;
   localparam int unsigned BLINK_DIV   = 16;

   logic       clk;
   logic       rst;
   logic [2:0] m10;
   logic [3:0] m1;
   logic [2:0] s10;
   logic [3:0] s1;
   logic       adj;
   logic       sel;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      string      tag;
   } exp_t;

   exp_t exp_q[$];
   event chk_now;
   int   n_vec  = 0;
   int   n_miss = 0;
   int   frame_no = 0;

   logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
   logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   seg_display_scan #(
      .REFRESH_DIV(REFRESH_DIV),
      .BLINK_DIV  (BLINK_DIV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .m10(m10),
      .m1 (m1),
      .s10(s10),
      .s1 (s1),
      .adj(adj),
      .sel(sel),
      .an (an),
      .seg(seg),
      .dp (dp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: compares the pins against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or chk_now);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
               n_miss++;
               $display("FAIL %s: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
                        e.tag, an, seg, dp, e.an, e.seg, e.dp);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic push_exp(input logic [3:0] a, input logic [6:0] s, input logic d,
                           input string tag);
      exp_t e;
      e.an  = a;
      e.seg = s;
      e.dp  = d;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   // One frame (or part of one): e0..e3 are the codes shown for s1,s10,m1,m10.
   // nin = {m10,m1,s10,s1} is driven mid-frame, during the idx=1 slot.
   task automatic run_frame(input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3,
                            input logic [13:0] nin, input bit drop_adj,
                            input int ncyc, input string tag);
      logic [6:0] ev [4];
      int         slot;
      logic       blank;
      ev = '{e0, e1, e2, e3};
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk);
         #1;
         slot  = c / 4;
         blank = adj && (frame_no % 2 == 1) && (sel ? (slot < 2) : (slot >= 2));
         push_exp(an_tab[slot], blank ? 7'h7F : ev[slot], (slot == 2 && !blank) ? 1'b0 : 1'b1,
                  tag);
         if (c == 5) {m10, m1, s10, s1} = nin;
         if (drop_adj && c == 9) adj = 1'b0;
      end
      if (ncyc == 16) frame_no++;
   endtask

   initial begin
      logic [13:0] nxt;
      m10 = 3'd5; m1 = 4'd9; s10 = 3'd5; s1 = 4'd9;
      adj = 1'b0; sel = 1'b0;
      rst = 1'b1;
      #1 rst = 1'b0;

      repeat (3) begin
         @(posedge clk);
         #1;
         push_exp(4'b1111, 7'h7F, 1'b1, "reset");
      end
      rst = 1'b1;

      run_frame(7'h40, 7'h40, 7'h40, 7'h40, {3'd5, 4'd9, 3'd5, 4'd9}, 0, 16, "first_frame");
      run_frame(7'h10, 7'h12, 7'h10, 7'h12, {3'd5, 4'd9, 3'd5, 4'd0}, 0, 16, "frame_5959");

      for (int v = 0; v < 16; v++) begin
         nxt = (v < 15) ? {3'd5, 4'd9, 3'd5, 4'(v + 1)} : {3'd6, 4'd9, 3'd7, 4'd3};
         run_frame(dec_tab[v], 7'h12, 7'h10, 7'h12, nxt, 0, 16, "decode_sweep");
      end

      run_frame(7'h30, 7'h3F, 7'h10, 7'h3F, {3'd0, 4'd0, 3'd5, 4'd9}, 0, 16, "dash_3bit");
      run_frame(7'h10, 7'h12, 7'h40, 7'h40, {3'd0, 4'd1, 3'd0, 4'd0}, 0, 16, "coherent_old");
      run_frame(7'h40, 7'h40, 7'h79, 7'h40, {3'd0, 4'd1, 3'd0, 4'd0}, 0, 16, "coherent_new");

      adj = 1'b1; sel = 1'b1;
      run_frame(7'h40, 7'h40, 7'h79, 7'h40, {3'd0, 4'd1, 3'd0, 4'd0}, 0, 16, "blink_sec_off");
      run_frame(7'h40, 7'h40, 7'h79, 7'h40, {3'd0, 4'd1, 3'd0, 4'd0}, 0, 16, "blink_sec_on");
      sel = 1'b0;
      run_frame(7'h40, 7'h40, 7'h79, 7'h40, {3'd0, 4'd1, 3'd0, 4'd0}, 0, 16, "blink_min_off");
      run_frame(7'h40, 7'h40, 7'h79, 7'h40, {3'd0, 4'd1, 3'd0, 4'd0}, 0, 16, "blink_min_on");
      run_frame(7'h40, 7'h40, 7'h79, 7'h40, {3'd0, 4'd1, 3'd0, 4'd0}, 1, 16, "adj_drop");

      run_frame(7'h40, 7'h40, 7'h79, 7'h40, {3'd0, 4'd1, 3'd0, 4'd0}, 0, 8, "pre_reset");
      // Scan is now in the idx=2 slot; pulse reset between edges.
      #5;
      rst = 1'b0;
      #1;
      push_exp(4'b1111, 7'h7F, 1'b1, "async_reset");
      -> chk_now;
      #1;
      rst = 1'b1;
      frame_no = 0;
      run_frame(7'h40, 7'h40, 7'h40, 7'h40, {3'd0, 4'd1, 3'd0, 4'd0}, 0, 16, "restart");
      run_frame(7'h40, 7'h40, 7'h79, 7'h40, {3'd0, 4'd1, 3'd0, 4'd0}, 0, 16, "after_restart");

      repeat (2) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
